// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS multiply/divide unit that owns the HI/LO
// registers. Multiply is shift-add and divide is restoring division, one bit
// per cycle. Signed operations run on magnitudes, and the sign is fixed up at
// commit.
//
// Handshake: Start is a one-cycle request that is sampled only while the FSM is
// IDLE, and the bench/hazard unit must not raise it while Busy is high.
// Iterative ops hold Busy for WIDTH+1 cycles. Done pulses for one cycle after
// HI/LO commit, and a new Start may be issued in that same cycle.
// MTHI/MTLO write HI/LO on the accepting edge and never raise Busy.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [2:0]       MDOp,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t               state;
    logic [CW-1:0]        count;
    // Multiply: {partial product high, multiplier being shifted out}.
    // Divide: the low half holds the dividend, which shifts out while the quotient shifts in.
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH:0]       rem;
    logic [WIDTH-1:0]     opnd;      // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0]     a_raw;     // original dividend, returned in HI on divide by zero
    logic                 is_div;
    logic                 res_neg;
    logic                 rem_neg;
    logic                 div_zero;

    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    assign dbg_state = state;

    // Operand magnitudes at acceptance, one iteration step, and the commit-time sign fix.
    always_comb begin
        a_neg     = ~MDOp[0] & SrcAE[WIDTH-1];
        b_neg     = ~MDOp[0] & SrcBE[WIDTH-1];
        a_mag     = a_neg ? (~SrcAE + 1'b1) : SrcAE;
        b_mag     = b_neg ? (~SrcBE + 1'b1) : SrcBE;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        prod_fix  = res_neg ? (~acc + 1'b1) : acc;
        quot_fix  = res_neg ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem_fix   = rem_neg ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
    end

    // Control FSM with the datapath registers and the registered Busy/Done/HI/LO outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            rem      <= '0;
            opnd     <= '0;
            a_raw    <= '0;
            is_div   <= 1'b0;
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            HI       <= '0;
            LO       <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        case (MDOp)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                is_div   <= MDOp[1];
                                res_neg  <= a_neg ^ b_neg;
                                rem_neg  <= a_neg;
                                div_zero <= MDOp[1] && (SrcBE == '0);
                                a_raw    <= SrcAE;
                                rem      <= '0;
                                count    <= '0;
                                opnd     <= MDOp[1] ? b_mag : a_mag;
                                acc      <= {{WIDTH{1'b0}}, (MDOp[1] ? a_mag : b_mag)};
                                Busy     <= 1'b1;
                                state    <= RUN;
                            end
                            3'b100:  HI <= SrcAE;
                            3'b101:  LO <= SrcAE;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (is_div) begin
                        if (!div_diff[WIDTH]) begin
                            rem             <= div_diff;
                            acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], 1'b1};
                        end else begin
                            rem             <= div_shift;
                            acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    if (!is_div) begin
                        HI <= prod_fix[2*WIDTH-1:WIDTH];
                        LO <= prod_fix[WIDTH-1:0];
                    end else if (div_zero) begin
                        HI <= a_raw;
                        LO <= '1;
                    end else begin
                        HI <= rem_fix;
                        LO <= quot_fix;
                    end
                    Busy  <= 1'b0;
                    Done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
